// File: rtl/shift_register_in_frame_if.sv
// Interface bundling the capture controls, serial input and the word handshake
// of shift_register_in_frame. Clock and reset stay as plain ports.
interface shift_register_in_frame_if #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 7
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  bit_length;
    logic                  lsb_first;
    logic                  data_load;
    logic                  sdi;
    logic                  clear_register;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  busy;
    logic                  overrun;

    // Driver side: the SPI sequencer and the register-read consumer.
    modport master (
        output start, bit_length, lsb_first, data_load, sdi, clear_register, data_ready,
        input  data_out, data_valid, busy, overrun
    );

    // Capture block side.
    modport slave (
        input  start, bit_length, lsb_first, data_load, sdi, clear_register, data_ready,
        output data_out, data_valid, busy, overrun
    );
endinterface

// File: rtl/shift_register_in_frame.sv
// Length-programmable serial input shift register with a one-deep output
// buffer and valid/ready handshake. Frames of 1..DATA_WIDTH bits are captured
// MSB- or LSB-first and right-justified; words that cannot be buffered set
// the sticky overrun flag.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; data_load is ignored
//   SHIFT | capturing bits on data_load until count reaches the length
module shift_register_in_frame #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 7
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    shift_register_in_frame_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] word_next;
    logic [LEN_WIDTH-1:0]  count;
    logic [LEN_WIDTH-1:0]  count_plus;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  len_clamped;
    logic                  order_q;
    logic                  arm;
    logic                  capture;
    logic                  done;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_q;
    logic                  overrun_q;

    // Oversized lengths saturate at the register width.
    assign len_clamped = (bus.bit_length > LEN_WIDTH'(DATA_WIDTH)) ?
                         LEN_WIDTH'(DATA_WIDTH) : bus.bit_length;
    assign count_plus  = count + LEN_WIDTH'(1);

    // The shift register starts zeroed, so either order leaves the bits above
    // the frame length at zero without explicit masking.
    assign word_next = order_q ? (shreg | (DATA_WIDTH'(bus.sdi) << count))
                               : ((shreg << 1) | DATA_WIDTH'(bus.sdi));

    // State register.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state = state;
        arm        = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        if (bus.clear_register) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && (len_clamped != '0)) begin
                        arm        = 1'b1;
                        next_state = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.data_load) begin
                        capture = 1'b1;
                        if (count_plus == len_q) begin
                            done       = 1'b1;
                            next_state = IDLE;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Frame parameters, shift register and bit counter.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            count   <= '0;
            len_q   <= '0;
            order_q <= 1'b0;
        end else if (bus.clear_register) begin
            shreg   <= '0;
            count   <= '0;
        end else if (arm) begin
            shreg   <= '0;
            count   <= '0;
            len_q   <= len_clamped;
            order_q <= bus.lsb_first;
        end else if (capture) begin
            shreg   <= word_next;
            count   <= count_plus;
        end
    end

    // One-deep output buffer; a completed word may replace one being consumed
    // in the same cycle, otherwise it is dropped and flagged.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (bus.clear_register) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (done) begin
            if (!valid_q || bus.data_ready) begin
                data_out_q <= word_next;
                valid_q    <= 1'b1;
            end else begin
                overrun_q  <= 1'b1;
            end
        end else if (valid_q && bus.data_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state == SHIFT);

endmodule

// File: tb/tb_shift_register_in_frame.sv
// Directed bench for shift_register_in_frame: frames are driven step by step,
// expected words are queued from a bit-level model and popped when the DUT
// presents data_valid.
module tb_shift_register_in_frame;

    localparam int DW = 64;
    localparam int LW = 7;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [DW-1:0] sb_q[$];

    shift_register_in_frame_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    shift_register_in_frame #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .CLK100MHZ (clk),
        .reset     (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected right-justified word for a frame; bits[k] is the k-th wire bit.
    function automatic logic [DW-1:0] model(input int len, input bit lsb, input logic [127:0] bits);
        logic [DW-1:0] w;
        int l;
        w = '0;
        l = (len > DW) ? DW : len;
        for (int k = 0; k < l; k++) begin
            if (lsb) w[k] = bits[k];
            else     w[l-1-k] = bits[k];
        end
        return w;
    endfunction

    // Arm a frame and strobe nbits bits with gap idle cycles between strobes.
    task automatic send_frame(input int len, input bit lsb, input logic [127:0] bits,
                              input int nbits, input int gap, input bit ready_last,
                              output int busy_cycles);
        busy_cycles = 0;
        bus.start      = 1'b1;
        bus.bit_length = LW'(len);
        bus.lsb_first  = lsb;
        tick();
        bus.start = 1'b0;
        if (bus.busy) busy_cycles++;
        for (int i = 0; i < nbits; i++) begin
            bus.data_load = 1'b1;
            bus.sdi       = bits[i];
            if (ready_last && i == nbits - 1) bus.data_ready = 1'b1;
            tick();
            bus.data_load  = 1'b0;
            bus.data_ready = 1'b0;
            if (bus.busy) busy_cycles++;
            if (i < nbits - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (bus.busy) busy_cycles++;
                end
            end
        end
    endtask

    // Wait (bounded) for a word, compare against the scoreboard, then consume it.
    task automatic pop_check(input string tag);
        logic [DW-1:0] exp;
        int n;
        n = 0;
        while (!bus.data_valid && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.data_valid) begin
            errors++;
            $error("FAIL %s_timeout observed=0 expected=data_valid", tag);
            void'(sb_q.pop_front());
            return;
        end
        exp = sb_q.pop_front();
        check(tag, bus.data_out, exp);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        check({tag, "_consumed"}, DW'(bus.data_valid), '0);
    endtask

    function automatic logic [127:0] pack8(input logic [7:0] seq);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[i] = seq[7-i];
        return b;
    endfunction

    initial begin
        int bc;
        logic [127:0] b8;
        logic [127:0] alt;
        logic [127:0] b4a;
        logic [127:0] b4b;
        checks = 0;
        errors = 0;
        bus.start = 0; bus.bit_length = '0; bus.lsb_first = 0; bus.data_load = 0;
        bus.sdi = 0; bus.clear_register = 0; bus.data_ready = 0;
        rst = 1'b1;
        #1;
        check("reset_data_out", bus.data_out, '0);
        check("reset_valid", DW'(bus.data_valid), '0);
        check("reset_busy", DW'(bus.busy), '0);
        check("reset_overrun", DW'(bus.overrun), '0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // MSB-first, L=8, bits 1,0,1,1,0,0,1,0 back-to-back
        b8 = pack8(8'b1011_0010);
        bus.start = 1'b1; bus.bit_length = 7'd8; bus.lsb_first = 1'b0;
        tick();
        bus.start = 1'b0;
        sb_q.push_back(model(8, 1'b0, b8));
        bc = 0;
        if (bus.busy) bc++;
        for (int i = 0; i < 8; i++) begin
            bus.data_load = 1'b1; bus.sdi = b8[i];
            tick();
            bus.data_load = 1'b0;
            if (bus.busy) bc++;
            if (i == 6) check("msb8_valid_early", DW'(bus.data_valid), '0);
        end
        check("msb8_valid_after_last", DW'(bus.data_valid), 64'd1);
        check("msb8_busy_cycles", DW'(bc), 64'd8);
        check("msb8_literal", bus.data_out, 64'hB2);
        pop_check("msb8");

        // LSB-first, L=8, gapped strobes
        send_frame(8, 1'b1, b8, 8, 2, 1'b0, bc);
        sb_q.push_back(model(8, 1'b1, b8));
        check("lsb8_literal", bus.data_out, 64'h4D);
        pop_check("lsb8_gap");

        // Full width and clamped length
        alt = '0;
        for (int i = 0; i < 64; i += 2) alt[i] = 1'b1;
        send_frame(64, 1'b0, alt, 64, 0, 1'b0, bc);
        sb_q.push_back(model(64, 1'b0, alt));
        check("full_literal", bus.data_out, 64'hAAAA_AAAA_AAAA_AAAA);
        pop_check("full64");
        send_frame(100, 1'b0, alt, 64, 0, 1'b0, bc);
        sb_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
        check("clamp_busy_cycles", DW'(bc), 64'd64);
        pop_check("clamp100");

        // Zero length is ignored
        bus.start = 1'b1; bus.bit_length = '0;
        tick();
        bus.start = 1'b0;
        check("len0_busy", DW'(bus.busy), '0);
        bus.data_load = 1'b1; bus.sdi = 1'b1;
        tick(); tick();
        bus.data_load = 1'b0;
        check("len0_valid", DW'(bus.data_valid), '0);

        // Overrun: second frame dropped while first is unconsumed
        b4a = 128'b0101;  // wire order 1,0,1,0
        b4b = 128'b1010;  // wire order 0,1,0,1
        send_frame(4, 1'b0, b4a, 4, 0, 1'b0, bc);
        send_frame(4, 1'b0, b4b, 4, 0, 1'b0, bc);
        check("ovr_data_kept", bus.data_out, 64'hA);
        check("ovr_flag", DW'(bus.overrun), 64'd1);
        check("ovr_valid", DW'(bus.data_valid), 64'd1);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        check("ovr_sticky", DW'(bus.overrun), 64'd1);
        bus.clear_register = 1'b1;
        tick();
        bus.clear_register = 1'b0;
        check("clr_overrun", DW'(bus.overrun), '0);

        // Replacement in the consume cycle is not an overrun
        send_frame(4, 1'b0, b4a, 4, 0, 1'b0, bc);
        send_frame(4, 1'b0, b4b, 4, 0, 1'b1, bc);
        check("swap_data", bus.data_out, 64'h5);
        check("swap_valid", DW'(bus.data_valid), 64'd1);
        check("swap_overrun", DW'(bus.overrun), '0);
        sb_q.push_back(64'h5);
        pop_check("swap_pop");

        // Clear mid-frame
        send_frame(8, 1'b0, b8, 3, 0, 1'b0, bc);
        bus.clear_register = 1'b1; bus.data_load = 1'b1; bus.sdi = 1'b1;
        tick();
        bus.clear_register = 1'b0;
        check("clr_busy", DW'(bus.busy), '0);
        check("clr_data", bus.data_out, '0);
        for (int i = 0; i < 6; i++) tick();
        bus.data_load = 1'b0;
        check("clr_ignored_valid", DW'(bus.data_valid), '0);
        send_frame(8, 1'b0, b8, 8, 1, 1'b0, bc);
        sb_q.push_back(model(8, 1'b0, b8));
        pop_check("after_clear");

        // Async reset mid-frame with a word pending
        send_frame(8, 1'b1, b8, 8, 0, 1'b0, bc);
        send_frame(8, 1'b0, b8, 4, 0, 1'b0, bc);
        #2 rst = 1'b1;
        #1;
        check("arst_data", bus.data_out, '0);
        check("arst_valid", DW'(bus.data_valid), '0);
        check("arst_busy", DW'(bus.busy), '0);
        tick();
        rst = 1'b0;
        tick();
        send_frame(8, 1'b1, b8, 8, 0, 1'b0, bc);
        sb_q.push_back(model(8, 1'b1, b8));
        pop_check("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
